xor_encrypt_core: RTL and testbench
===================================

Name: xor_encrypt_core

Overview:
Byte-wide XOR stream cipher placed ahead of the UART transmitter. It accepts one plaintext byte per enable assertion and XORs it with a key rotated left by `shift`. An optional chained ("improved") mode also XORs the previous ciphertext into each byte. It outputs a registered cipher byte and a completion LED for the last byte of a message.

Parameters:
DATA_W, 8, width of din/key/dout (the rotate logic is defined for 8 bits)
SHIFT_W, 3, width of the shift amount (0..7)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
shift  in  SHIFT_W  left-rotate amount applied to key
key  in  DATA_W  cipher key
din  in  DATA_W  plaintext byte
start_reset  in  1  synchronous active-high soft clear (message restart)
xor_enable  in  1  request simple-cipher processing of din
improved_encrypt_enable  in  1  request chained-cipher processing of din
last_data  in  1  marks the current byte as last of a message
dout  out  DATA_W  registered cipher byte
led_complete  out  1  sticky "message complete" flag

Behaviour:
- Reset (rst_n=0 at clk edge) clears these to 0: dout, led_complete, chain register, both enable-history registers. Reset has priority over everything.
- start_reset=1 (with rst_n=1) has the same clearing effect and overrides any accept in that cycle.
- Effective key is rotl(key, shift). Example: key 0xA8, shift 7 gives 0x54.
- Accept rule is edge-based:
  - A byte is accepted in a cycle where an enable is 1 and was 0 in the previous cycle.
  - Holding an enable high processes exactly one byte.
- Simultaneous rising edges on both enables: the improved request wins.
- Simple accept: dout <= din ^ rotl(key, shift) at the accepting edge (1-cycle latency). The chain register is unchanged.
- Improved accept: dout <= din ^ rotl(key, shift) ^ chain, and chain <= that same value. The chain is cleared by reset and start_reset, so the first byte after a clear equals the simple result.
- dout holds its value between accepts. din, key and shift changes have no effect until the next accept.
- led_complete:
  - Set to 1 on any accept whose sampled last_data=1.
  - Stays 1 until reset or start_reset.
  - An accept with last_data=0 does not clear it.
- No backpressure. One accept per rising edge of an enable. Inputs are sampled in the accept cycle only.

Optional Feature:
IMPROVED_CIPHER_EN.
- Defined: improved mode and the chain register are present as above.
- Undefined:
  - improved_encrypt_enable is ignored (its port is kept) and the chain register is not built.
  - Only the simple cipher exists.

Decomposition:
- Package xor_cipher_pkg holds:
  - localparams DATA_W=8, SHIFT_W=3
  - a rotl8(data, amt) function
  - a typedef byte_t
- One natural sub-module: key_rotator (combinational, key and shift in, rotated key out). The top holds the edge detectors, dout, chain and LED registers.

Test Plan:
- din 0x61, key 0x80, shift 0, xor_enable held high 10 cycles -> dout=0xE1 one cycle after the rise, then stable; led_complete=0.
- din 0x3F, key 0xA8, shift 7, xor_enable pulse -> dout=0x6B.
- start_reset pulse, key 0x80, shift 0; improved pulses with din 0x61, then 0x62 -> dout 0xE1 then 0x03.
- Improved byte with last_data=1 -> led_complete=1, held through further accepts; start_reset -> led_complete=0, dout=0x00, chain=0 (next improved 0x61 gives 0xE1).
- Both enables rise in the same cycle after chain=0xE1, din 0x62 -> improved result 0x03. Then rst_n=0 mid-message -> all outputs 0 at the next edge.
- Build without IMPROVED_CIPHER_EN: an improved_encrypt_enable pulse leaves dout unchanged; xor_enable behaves as in the first scenario.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: shared widths, byte type and the 8-bit left-rotate helper
package xor_cipher_pkg;
    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;
    typedef logic [DATA_W-1:0] byte_t;
    function automatic byte_t rotl8(input byte_t data, input logic [SHIFT_W-1:0] amt);
        logic [2*DATA_W-1:0] w;
        w = {data, data} << amt;
        return w[2*DATA_W-1:DATA_W];
    endfunction
endpackage

// File: rtl/xor_encrypt_core_if.sv
// xor_encrypt_core_if: cipher request/result bundle; master drives shift/key/din/controls, slave drives dout/led_complete
interface xor_encrypt_core_if;
    import xor_cipher_pkg::*;
    logic [SHIFT_W-1:0] shift;
    byte_t              key;
    byte_t              din;
    logic               start_reset;
    logic               xor_enable;
    logic               improved_encrypt_enable;
    logic               last_data;
    byte_t              dout;
    logic               led_complete;
    modport master (
        output shift, key, din, start_reset, xor_enable, improved_encrypt_enable, last_data,
        input  dout, led_complete
    );
    modport slave (
        input  shift, key, din, start_reset, xor_enable, improved_encrypt_enable, last_data,
        output dout, led_complete
    );
endinterface

// File: rtl/key_rotator.sv
// key_rotator: combinational key rotate; key_i rotated left by shift_i gives key_o
module key_rotator
    import xor_cipher_pkg::*;
(
    input  byte_t              key_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output byte_t              key_o
);
    assign key_o = rotl8(key_i, shift_i);
endmodule

// File: rtl/xor_encrypt_core.sv
// xor_encrypt_core: edge-accepted XOR byte cipher (clk, rst_n sync active-low, bus slave); chained mode under IMPROVED_CIPHER_EN
module xor_encrypt_core
    import xor_cipher_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    xor_encrypt_core_if.slave  bus
);
    byte_t rkey, dout_q, dout_d, chain_cur;
    logic  xen_q, led_q, led_d, x_rise, i_rise, accept;
    key_rotator u_rot (.key_i(bus.key), .shift_i(bus.shift), .key_o(rkey));
    assign x_rise = bus.xor_enable & ~xen_q;
`ifdef IMPROVED_CIPHER_EN
    logic  ien_q;
    byte_t chain_q, chain_d;
    assign i_rise    = bus.improved_encrypt_enable & ~ien_q;
    assign chain_cur = chain_q;
    assign chain_d   = i_rise ? dout_d : chain_q;
`else
    logic unused_imp;
    assign unused_imp = bus.improved_encrypt_enable;
    assign i_rise     = 1'b0;
    assign chain_cur  = '0;
`endif
    // improved wins on a simultaneous rise: only it folds the chain in
    assign accept = x_rise | i_rise;
    always_comb begin
        dout_d = accept ? (bus.din ^ rkey ^ (i_rise ? chain_cur : '0)) : dout_q;
        led_d  = led_q | (accept & bus.last_data);
    end
    always_ff @(posedge clk) begin
        if (!rst_n || bus.start_reset) begin
            dout_q <= '0;
            led_q  <= 1'b0;
            xen_q  <= 1'b0;
`ifdef IMPROVED_CIPHER_EN
            ien_q   <= 1'b0;
            chain_q <= '0;
`endif
        end else begin
            dout_q <= dout_d;
            led_q  <= led_d;
            xen_q  <= bus.xor_enable;
`ifdef IMPROVED_CIPHER_EN
            ien_q   <= bus.improved_encrypt_enable;
            chain_q <= chain_d;
`endif
        end
    end
    assign bus.dout         = dout_q;
    assign bus.led_complete = led_q;
endmodule

// File: tb/tb_xor_encrypt_core.sv
// tb_xor_encrypt_core: table-driven and sequence checks of xor_encrypt_core through a scoreboard queue
module tb_xor_encrypt_core;
    import xor_cipher_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    xor_encrypt_core_if bus();
    xor_encrypt_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        byte_t      din;
        byte_t      key;
        logic [2:0] shift;
        logic       last;
        byte_t      dout;
        logic       led;
    } vec_t;
    typedef struct {
        byte_t dout;
        logic  led;
    } exp_t;
    exp_t sb[$];
    vec_t vt[7];
    int errors = 0;
    int checks = 0;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input byte_t d, input logic l);
        exp_t e;
        e.dout = d;
        e.led  = l;
        sb.push_back(e);
    endtask
    task automatic check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.dout !== e.dout) begin
            errors++;
            $display("FAIL %s dout: got %h want %h", name, bus.dout, e.dout);
        end
        checks++;
        if (bus.led_complete !== e.led) begin
            errors++;
            $display("FAIL %s led: got %b want %b", name, bus.led_complete, e.led);
        end
    endtask
    task automatic pulse(input string name, input logic xe, input logic ie, input byte_t d,
                         input byte_t k, input logic [2:0] s, input logic last,
                         input byte_t ed, input logic el);
        bus.din = d;
        bus.key = k;
        bus.shift = s;
        bus.last_data = last;
        bus.xor_enable = xe;
        bus.improved_encrypt_enable = ie;
        push(ed, el);
        tick;
        check(name);
        bus.xor_enable = 1'b0;
        bus.improved_encrypt_enable = 1'b0;
        bus.last_data = 1'b0;
        tick;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        vt[0] = '{8'h61, 8'h80, 3'd0, 1'b0, 8'hE1, 1'b0};
        vt[1] = '{8'h3F, 8'hA8, 3'd7, 1'b0, 8'h6B, 1'b0};
        vt[2] = '{8'h00, 8'h01, 3'd1, 1'b0, 8'h02, 1'b0};
        vt[3] = '{8'hFF, 8'h0F, 3'd4, 1'b0, 8'h0F, 1'b0};
        vt[4] = '{8'hAA, 8'h81, 3'd3, 1'b1, 8'hA6, 1'b1};
        vt[5] = '{8'h55, 8'h00, 3'd5, 1'b0, 8'h55, 1'b1};
        vt[6] = '{8'h12, 8'h34, 3'd2, 1'b0, 8'hC2, 1'b1};
        rst_n = 1'b0;
        bus.shift = '0;
        bus.key = '0;
        bus.din = '0;
        bus.start_reset = 1'b0;
        bus.xor_enable = 1'b0;
        bus.improved_encrypt_enable = 1'b0;
        bus.last_data = 1'b0;
        tick;
        tick;
        push(8'h00, 1'b0);
        check("reset");
        rst_n = 1'b1;
        tick;
        bus.din = 8'h61;
        bus.key = 8'h80;
        bus.shift = 3'd0;
        bus.xor_enable = 1'b1;
        push(8'hE1, 1'b0);
        tick;
        check("hold_rise");
        bus.din = 8'h00;
        for (int i = 0; i < 9; i++) begin
            push(8'hE1, 1'b0);
            tick;
            check("hold_stable");
        end
        bus.xor_enable = 1'b0;
        tick;
        for (int i = 0; i < 7; i++)
            pulse($sformatf("vec%0d", i), 1'b1, 1'b0, vt[i].din, vt[i].key, vt[i].shift,
                  vt[i].last, vt[i].dout, vt[i].led);
        bus.start_reset = 1'b1;
        bus.xor_enable = 1'b1;
        bus.din = 8'hFF;
        bus.key = 8'h00;
        push(8'h00, 1'b0);
        tick;
        check("soft_clear_over_accept");
        bus.start_reset = 1'b0;
        bus.xor_enable = 1'b0;
        push(8'h00, 1'b0);
        tick;
        check("soft_clear_hold");
`ifdef IMPROVED_CIPHER_EN
        pulse("imp_first", 1'b0, 1'b1, 8'h61, 8'h80, 3'd0, 1'b0, 8'hE1, 1'b0);
        pulse("imp_chain", 1'b0, 1'b1, 8'h62, 8'h80, 3'd0, 1'b0, 8'h03, 1'b0);
        pulse("imp_last", 1'b0, 1'b1, 8'h10, 8'h80, 3'd0, 1'b1, 8'h93, 1'b1);
        pulse("led_sticky", 1'b1, 1'b0, 8'h00, 8'h80, 3'd0, 1'b0, 8'h80, 1'b1);
        bus.start_reset = 1'b1;
        push(8'h00, 1'b0);
        tick;
        check("imp_soft_clear");
        bus.start_reset = 1'b0;
        pulse("imp_after_clear", 1'b0, 1'b1, 8'h61, 8'h80, 3'd0, 1'b0, 8'hE1, 1'b0);
        pulse("both_rise", 1'b1, 1'b1, 8'h62, 8'h80, 3'd0, 1'b0, 8'h03, 1'b0);
`else
        pulse("simple_base", 1'b1, 1'b0, 8'h61, 8'h80, 3'd0, 1'b0, 8'hE1, 1'b0);
        pulse("imp_ignored", 1'b0, 1'b1, 8'h33, 8'h80, 3'd0, 1'b1, 8'hE1, 1'b0);
        pulse("both_rise_simple", 1'b1, 1'b1, 8'h62, 8'h80, 3'd0, 1'b0, 8'hE2, 1'b0);
`endif
        pulse("pre_rst", 1'b1, 1'b0, 8'h00, 8'h0F, 3'd0, 1'b1, 8'h0F, 1'b1);
        rst_n = 1'b0;
        bus.xor_enable = 1'b1;
        bus.din = 8'h11;
        push(8'h00, 1'b0);
        tick;
        check("rst_mid_message");
        rst_n = 1'b1;
        bus.xor_enable = 1'b0;
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
